// File: rtl/rv32i_mem_pkg.sv
// Shared types for the RV32I MEM/WB stage: load/store funct3 encodings,
// transaction FSM states, the MEM pipeline register and the access legality check.
package rv32i_mem_pkg;

    localparam int MEM_OP_W = 3;

    typedef enum logic [MEM_OP_W-1:0] {
        OP_B  = 3'b000,
        OP_H  = 3'b001,
        OP_W  = 3'b010,
        OP_BU = 3'b100,
        OP_HU = 3'b101
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic                rd_en;
        logic                wr_en;
        logic [MEM_OP_W-1:0] op;
        logic                mem_to_reg;
        logic [31:0]         alu_result;
        logic [31:0]         rs2_data;
        logic [4:0]          rd_addr;
        logic                rf_wr_en;
    } mem_reg_t;

    // True when funct3 is a defined width and the address is naturally aligned for it.
    function automatic logic access_legal(input logic [MEM_OP_W-1:0] op,
                                          input logic [1:0]          addr_lo);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_B, OP_BU: ok = 1'b1;
            OP_H, OP_HU: ok = ~addr_lo[0];
            OP_W:        ok = (addr_lo == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rv32i_load_align.sv
// Extracts the addressed byte/half/word from a load word and sign- or
// zero-extends it according to funct3.
module rv32i_load_align
    import rv32i_mem_pkg::*;
(
    input  logic [31:0]         rdata,
    input  logic [1:0]          addr_lo,
    input  logic [MEM_OP_W-1:0] op,
    output logic [31:0]         data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (op)
            OP_B:    data = {{24{byte_sel[7]}}, byte_sel};
            OP_H:    data = {{16{half_sel[15]}}, half_sel};
            OP_BU:   data = {24'd0, byte_sel};
            OP_HU:   data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/rv32i_mem_wb.sv
// MEM and WB stages of the RV32I pipeline: one valid/ready data-memory
// transaction per load/store, forwarding taps, stall and write-back register.
module rv32i_mem_wb
    import rv32i_mem_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic                Clk,
    input  logic                Reset,

    input  logic                EX_Mem_rd_en,
    input  logic                EX_Mem_wr_en,
    input  logic [MEM_OP_W-1:0] EX_Mem_op,
    input  logic                EX_MemToReg,
    input  logic [31:0]         EX_ALU_result,
    input  logic [31:0]         EX_Rs2_data,
    input  logic [4:0]          EX_Rd_addr,
    input  logic                EX_RegFile_wr_en,

    output logic                DMem_req_valid,
    input  logic                DMem_req_ready,
    output logic [31:0]         DMem_addr,
    output logic                DMem_we,
    output logic [3:0]          DMem_be,
    output logic [31:0]         DMem_wdata,
    input  logic                DMem_rsp_valid,
    input  logic [31:0]         DMem_rdata,

    output logic                MEM_Stall,
    output logic [4:0]          MEM_Rd_addr,
    output logic                MEM_RegFile_wr_en,
    output logic [31:0]         MEM_Rd_data,

    output logic [4:0]          WB_Rd_addr,
    output logic                WB_RegFile_wr_en,
    output logic [31:0]         WB_Rd_data,

    output logic                MEM_Misaligned,
    output logic                MEM_Bus_err
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    mem_state_e       state_q, state_d;
    mem_reg_t         mem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bus_err_q;
    logic [4:0]       wb_rd_addr_q;
    logic             wb_wr_en_q;
    logic [31:0]      wb_data_q;

    logic             mem_access, misaligned;
    logic             in_req, in_resp;
    logic             req_done, rsp_done, timeout;
    logic             stall, fwd_wr_en;
    logic [31:0]      load_data;
    logic [3:0]       be_lane;
    logic [31:0]      wdata_lane;

    rv32i_load_align u_load_align (
        .rdata   (DMem_rdata),
        .addr_lo (mem_q.alu_result[1:0]),
        .op      (mem_q.op),
        .data    (load_data)
    );

    always_comb begin
        mem_access = mem_q.rd_en | mem_q.wr_en;
        misaligned = mem_access & ~access_legal(mem_q.op, mem_q.alu_result[1:0]);
        in_req     = (state_q == ST_REQ);
        in_resp    = (state_q == ST_RESP);
        req_done   = in_req & DMem_req_ready & mem_q.wr_en;
        rsp_done   = in_resp & DMem_rsp_valid;
        // A completion in the final allowed cycle beats the timeout.
        timeout    = (in_req | in_resp) & (cnt_q == CNT_W'(MEM_TIMEOUT - 1))
                     & ~req_done & ~rsp_done;
        stall      = ((in_req & ~(DMem_req_ready & mem_q.wr_en)) |
                      (in_resp & ~DMem_rsp_valid)) & ~timeout;
        fwd_wr_en  = mem_q.rf_wr_en & (mem_q.rd_addr != 5'd0) & ~misaligned & ~timeout;
    end

    // The next state follows the newly captured instruction whenever MEM advances.
    always_comb begin
        state_d = state_q;
        if (!stall) begin
            if ((EX_Mem_rd_en | EX_Mem_wr_en) && access_legal(EX_Mem_op, EX_ALU_result[1:0]))
                state_d = ST_REQ;
            else
                state_d = ST_IDLE;
        end else if (in_req && DMem_req_ready) begin
            state_d = ST_RESP;
        end
    end

    always_comb begin
        case (mem_q.op[1:0])
            2'b00: begin
                wdata_lane = {4{mem_q.rs2_data[7:0]}};
                be_lane    = 4'b0001 << mem_q.alu_result[1:0];
            end
            2'b01: begin
                wdata_lane = {2{mem_q.rs2_data[15:0]}};
                be_lane    = 4'b0011 << {mem_q.alu_result[1], 1'b0};
            end
            default: begin
                wdata_lane = mem_q.rs2_data;
                be_lane    = 4'b1111;
            end
        endcase

        DMem_req_valid = in_req;
        DMem_addr      = in_req ? {mem_q.alu_result[31:2], 2'b00} : '0;
        DMem_we        = in_req & mem_q.wr_en;
        DMem_be        = in_req ? be_lane : '0;
        DMem_wdata     = in_req ? wdata_lane : '0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            mem_q        <= '0;
            cnt_q        <= '0;
            bus_err_q    <= 1'b0;
            wb_rd_addr_q <= '0;
            wb_wr_en_q   <= 1'b0;
            wb_data_q    <= '0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= timeout;
            if (!stall) begin
                mem_q <= '{rd_en:      EX_Mem_rd_en,
                           wr_en:      EX_Mem_wr_en,
                           op:         EX_Mem_op,
                           mem_to_reg: EX_MemToReg,
                           alu_result: EX_ALU_result,
                           rs2_data:   EX_Rs2_data,
                           rd_addr:    EX_Rd_addr,
                           rf_wr_en:   EX_RegFile_wr_en};
                cnt_q        <= '0;
                wb_rd_addr_q <= mem_q.rd_addr;
                wb_wr_en_q   <= fwd_wr_en;
                wb_data_q    <= mem_q.mem_to_reg ? load_data : mem_q.alu_result;
            end else begin
                cnt_q        <= cnt_q + 1'b1;
                wb_rd_addr_q <= '0;
                wb_wr_en_q   <= 1'b0;
                wb_data_q    <= '0;
            end
        end
    end

    assign MEM_Stall         = stall;
    assign MEM_Rd_addr       = mem_q.rd_addr;
    assign MEM_RegFile_wr_en = fwd_wr_en;
    assign MEM_Rd_data       = mem_q.alu_result;
    assign WB_Rd_addr        = wb_rd_addr_q;
    assign WB_RegFile_wr_en  = wb_wr_en_q;
    assign WB_Rd_data        = wb_data_q;
    assign MEM_Misaligned    = misaligned;
    assign MEM_Bus_err       = bus_err_q;

endmodule

// File: tb/tb_rv32i_mem_wb.sv
// Directed and random load/store/ALU transactions through rv32i_mem_wb,
// checked cycle by cycle against a transaction-level reference model.
module tb_rv32i_mem_wb;

    localparam int unsigned TMO = 8;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        EX_Mem_rd_en, EX_Mem_wr_en, EX_MemToReg, EX_RegFile_wr_en;
    logic [2:0]  EX_Mem_op;
    logic [31:0] EX_ALU_result, EX_Rs2_data;
    logic [4:0]  EX_Rd_addr;
    logic        DMem_req_valid, DMem_req_ready, DMem_we, DMem_rsp_valid;
    logic [31:0] DMem_addr, DMem_wdata, DMem_rdata;
    logic [3:0]  DMem_be;
    logic        MEM_Stall, MEM_RegFile_wr_en, WB_RegFile_wr_en;
    logic [4:0]  MEM_Rd_addr, WB_Rd_addr;
    logic [31:0] MEM_Rd_data, WB_Rd_data;
    logic        MEM_Misaligned, MEM_Bus_err;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    rv32i_mem_wb #(.MEM_TIMEOUT(TMO)) dut (
        .Clk(Clk), .Reset(Reset),
        .EX_Mem_rd_en(EX_Mem_rd_en), .EX_Mem_wr_en(EX_Mem_wr_en),
        .EX_Mem_op(EX_Mem_op), .EX_MemToReg(EX_MemToReg),
        .EX_ALU_result(EX_ALU_result), .EX_Rs2_data(EX_Rs2_data),
        .EX_Rd_addr(EX_Rd_addr), .EX_RegFile_wr_en(EX_RegFile_wr_en),
        .DMem_req_valid(DMem_req_valid), .DMem_req_ready(DMem_req_ready),
        .DMem_addr(DMem_addr), .DMem_we(DMem_we), .DMem_be(DMem_be),
        .DMem_wdata(DMem_wdata), .DMem_rsp_valid(DMem_rsp_valid),
        .DMem_rdata(DMem_rdata),
        .MEM_Stall(MEM_Stall), .MEM_Rd_addr(MEM_Rd_addr),
        .MEM_RegFile_wr_en(MEM_RegFile_wr_en), .MEM_Rd_data(MEM_Rd_data),
        .WB_Rd_addr(WB_Rd_addr), .WB_RegFile_wr_en(WB_RegFile_wr_en),
        .WB_Rd_data(WB_Rd_data),
        .MEM_Misaligned(MEM_Misaligned), .MEM_Bus_err(MEM_Bus_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rd_en, wr_en, m2r, rf_we;
        logic [2:0]  op;
        logic [31:0] alu, rs2, rdata;
        logic [4:0]  rd;
        int unsigned rdly;   // cycles ready is withheld in REQ
        int unsigned pdly;   // RESP cycles before rsp_valid
    } txn_t;

    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed 0x%08h expected 0x%08h", tag, what, obs, exp);
        end
    endtask

    function automatic int unsigned op_bytes(input logic [2:0] op);
        case (op)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] rdata,
                                             input logic [31:0] addr);
        logic [31:0] w, b, h;
        w = rdata >> (8 * (addr % 4));
        b = w & 32'hFF;
        h = w & 32'hFFFF;
        case (op)
            3'd0:    return (b >= 128)   ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    function automatic txn_t mk(input int unsigned kind, input logic [2:0] op,
                                input logic [31:0] alu, input logic [31:0] rs2,
                                input logic [4:0] rd, input int unsigned rdly,
                                input int unsigned pdly, input logic [31:0] rdata);
        txn_t t;
        t.rd_en = (kind == 1); t.wr_en = (kind == 2);
        t.m2r   = (kind == 1); t.rf_we = (kind != 2);
        t.op = op; t.alu = alu; t.rs2 = rs2; t.rd = rd;
        t.rdly = rdly; t.pdly = pdly; t.rdata = rdata;
        return t;
    endfunction

    task automatic drive_nop();
        EX_Mem_rd_en = 1'b0; EX_Mem_wr_en = 1'b0; EX_Mem_op = 3'd0; EX_MemToReg = 1'b0;
        EX_ALU_result = '0; EX_Rs2_data = '0; EX_Rd_addr = '0; EX_RegFile_wr_en = 1'b0;
    endtask

    // Issue one instruction from EX and follow it through MEM and WB.
    task automatic run(input txn_t t, input string tag);
        int unsigned nb, nreq, n, ne, sh;
        logic        mem, ok, is_load, tmo, rv, exp_we;
        logic [31:0] exp_be, exp_wd, exp_data;
        nb      = op_bytes(t.op);
        mem     = t.rd_en | t.wr_en;
        ok      = mem && (nb != 0) && ((t.alu % nb) == 0);
        is_load = ok && !t.wr_en;
        nreq    = t.rdly + 1;
        n       = !ok ? 1 : (t.wr_en ? nreq : nreq + t.pdly + 1);
        tmo     = (n > TMO);
        ne      = tmo ? TMO : n;
        sh      = t.alu % 4;
        exp_be  = (nb == 0) ? 0 : (((32'd1 << nb) - 1) << sh);
        exp_wd  = (nb == 1) ? (t.rs2 & 32'hFF) * 32'h0101_0101 :
                  (nb == 2) ? (t.rs2 & 32'hFFFF) * 32'h0001_0001 : t.rs2;
        exp_we  = t.rf_we && (t.rd != 0) && !(mem && !ok) && !tmo;
        exp_data = t.m2r ? ref_load(t.op, t.rdata, t.alu) : t.alu;

        EX_Mem_rd_en = t.rd_en; EX_Mem_wr_en = t.wr_en; EX_Mem_op = t.op;
        EX_MemToReg = t.m2r; EX_ALU_result = t.alu; EX_Rs2_data = t.rs2;
        EX_Rd_addr = t.rd; EX_RegFile_wr_en = t.rf_we;
        @(posedge Clk); #1;
        drive_nop();
        for (int unsigned i = 1; i <= ne; i++) begin
            DMem_req_ready = ok && (i == nreq);
            DMem_rsp_valid = is_load && (i == n);
            DMem_rdata     = t.rdata;
            #1;
            rv = ok && (i <= nreq);
            check(tag, "req_valid", {31'd0, DMem_req_valid}, {31'd0, rv});
            if (rv) begin
                check(tag, "addr",  DMem_addr, t.alu & 32'hFFFF_FFFC);
                check(tag, "we",    {31'd0, DMem_we}, {31'd0, t.wr_en});
                if (t.wr_en) begin
                    check(tag, "be",    {28'd0, DMem_be}, exp_be);
                    check(tag, "wdata", DMem_wdata, exp_wd);
                end
            end
            check(tag, "stall", {31'd0, MEM_Stall}, {31'd0, ok && (i < ne)});
            check(tag, "misaligned", {31'd0, MEM_Misaligned}, {31'd0, (i == 1) && mem && !ok});
            check(tag, "wb_bubble", {31'd0, WB_RegFile_wr_en}, 32'd0);
            if (i == 1) begin
                check(tag, "mem_rd_addr", {27'd0, MEM_Rd_addr}, {27'd0, t.rd});
                check(tag, "mem_rd_data", MEM_Rd_data, t.alu);
                check(tag, "mem_wr_en", {31'd0, MEM_RegFile_wr_en},
                      {31'd0, t.rf_we && (t.rd != 0) && !(mem && !ok)});
            end
            @(posedge Clk); #1;
        end
        DMem_req_ready = 1'b0;
        DMem_rsp_valid = 1'b0;
        #1;
        check(tag, "wb_wr_en", {31'd0, WB_RegFile_wr_en}, {31'd0, exp_we});
        check(tag, "bus_err", {31'd0, MEM_Bus_err}, {31'd0, tmo});
        if (exp_we) begin
            check(tag, "wb_rd_addr", {27'd0, WB_Rd_addr}, {27'd0, t.rd});
            check(tag, "wb_rd_data", WB_Rd_data, exp_data);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, "req_valid", {31'd0, DMem_req_valid}, 32'd0);
        check(tag, "stall", {31'd0, MEM_Stall}, 32'd0);
        check(tag, "wb_wr_en", {31'd0, WB_RegFile_wr_en}, 32'd0);
        check(tag, "wb_rd_addr", {27'd0, WB_Rd_addr}, 32'd0);
        check(tag, "wb_rd_data", WB_Rd_data, 32'd0);
        check(tag, "mem_rd_addr", {27'd0, MEM_Rd_addr}, 32'd0);
        check(tag, "mem_rd_data", MEM_Rd_data, 32'd0);
        check(tag, "faults", {30'd0, MEM_Misaligned, MEM_Bus_err}, 32'd0);
    endtask

    initial begin
        txn_t t;
        Reset = 1'b1;
        DMem_req_ready = 1'b0; DMem_rsp_valid = 1'b0; DMem_rdata = '0;
        drive_nop();
        repeat (2) @(posedge Clk);
        #1;
        check_all_zero("reset");
        Reset = 1'b0;

        run(mk(0, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 0, 0, 32'h0), "add");
        run(mk(2, 3'd0, 32'h0000_0103, 32'hAABB_CCDD, 5'd0, 2, 0, 32'h0), "sb");
        run(mk(2, 3'd1, 32'h0000_0206, 32'h1122_3344, 5'd0, 0, 0, 32'h0), "sh");
        run(mk(2, 3'd2, 32'h0000_0208, 32'hCAFE_F00D, 5'd0, 1, 0, 32'h0), "sw");
        run(mk(1, 3'd1, 32'h0000_0202, 32'h0, 5'd6, 0, 1, 32'h8001_FFFF), "lh");
        run(mk(1, 3'd5, 32'h0000_0202, 32'h0, 5'd6, 0, 1, 32'h8001_FFFF), "lhu");
        run(mk(1, 3'd0, 32'h0000_0011, 32'h0, 5'd9, 0, 0, 32'h1234_80FF), "lb");
        run(mk(1, 3'd2, 32'h0000_0301, 32'h0, 5'd7, 0, 0, 32'h0), "lw_misaligned");
        run(mk(1, 3'd3, 32'h0000_0300, 32'h0, 5'd7, 0, 0, 32'h0), "reserved_op");
        run(mk(1, 3'd2, 32'h0000_0400, 32'h0, 5'd8, 3, 1, 32'h5555_AAAA), "lw_slow");
        run(mk(1, 3'd2, 32'h0000_0400, 32'h0, 5'd0, 3, 1, 32'h5555_AAAA), "lw_rd0");
        run(mk(1, 3'd2, 32'h0000_0500, 32'h0, 5'd10, 0, 40, 32'h0), "timeout");
        run(mk(0, 3'd0, 32'h0000_0077, 32'h0, 5'd11, 0, 0, 32'h0), "after_timeout");

        // Reset lands while a load is waiting in RESP; the late response must be dropped.
        t = mk(1, 3'd2, 32'h0000_0600, 32'h0, 5'd12, 0, 5, 32'hDEAD_BEEF);
        EX_Mem_rd_en = 1'b1; EX_Mem_op = 3'd2; EX_MemToReg = 1'b1;
        EX_ALU_result = t.alu; EX_Rd_addr = t.rd; EX_RegFile_wr_en = 1'b1;
        @(posedge Clk); #1;
        drive_nop();
        DMem_req_ready = 1'b1; DMem_rdata = t.rdata;
        @(posedge Clk); #1;
        DMem_req_ready = 1'b0;
        #1;
        check("rst_mid", "stall_in_resp", {31'd0, MEM_Stall}, 32'd1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        DMem_rsp_valid = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(posedge Clk); #1;
        DMem_rsp_valid = 1'b0;
        #1;
        check("rst_mid", "late_rsp_wb", {31'd0, WB_RegFile_wr_en}, 32'd0);

        for (int k = 0; k < 150; k++) begin
            t = mk($urandom_range(0, 2), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   5'($urandom_range(0, 31)), $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
            if ($urandom_range(0, 1) == 1) t.alu = t.alu & 32'hFFFF_FFFC;
            if (!t.rd_en && !t.wr_en) t.rf_we = 1'($urandom_range(0, 1));
            run(t, "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
